// File: rtl/full_sub.sv
// rtl/full_sub.sv - one-bit full subtractor cell, purely combinational
module full_sub (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   always_comb begin
      d    = a ^ b ^ bin;
      bout = (~a & b) | (~(a ^ b) & bin);
   end

endmodule

// File: rtl/ripple_sub.sv
// rtl/ripple_sub.sv - WIDTH-bit ripple-borrow subtractor, s = a - b - c, registered result and borrow-out
module ripple_sub #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   logic [WIDTH:0]   bw;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] s_d;
   logic [WIDTH-1:0] s_q;
   logic             cout_d;
   logic             cout_q;

   assign bw[0] = c;

   // Borrow ripples LSB to MSB through one cell per bit.
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      full_sub u_cell (
         .a    (a[i]),
         .b    (b[i]),
         .bin  (bw[i]),
         .d    (d[i]),
         .bout (bw[i+1])
      );
   end

   always_comb begin
      s_d    = d;
      cout_d = bw[WIDTH];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_q    <= '0;
         cout_q <= 1'b0;
      end else begin
         s_q    <= s_d;
         cout_q <= cout_d;
      end
   end

   assign s    = s_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_ripple_sub.sv
// tb/tb_ripple_sub.sv - scoreboard bench for ripple_sub with directed and random vectors
module tb_ripple_sub;

   typedef struct {
      int         due;
      logic [3:0] s;
      logic       cout;
      string      name;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] a;
   logic [3:0] b;
   logic       c;
   logic [3:0] s;
   logic       cout;

   int   cyc    = 0;
   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   ripple_sub #(.WIDTH(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .a    (a),
      .b    (b),
      .c    (c),
      .s    (s),
      .cout (cout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Monitor: results appear one rising edge after the inputs were applied.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due == cyc) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if (s !== e.s || cout !== e.cout) begin
            errors++;
            $display("FAIL %s: got s=%b cout=%b, expected s=%b cout=%b",
                     e.name, s, cout, e.s, e.cout);
         end
      end
   end

   task automatic push_exp(input logic [3:0] es, input logic ec, input string nm);
      exp_t e;
      e.due  = cyc + 1;
      e.s    = es;
      e.cout = ec;
      e.name = nm;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic directed(input logic [3:0] ai, input logic [3:0] bi, input logic ci,
                           input logic [3:0] es, input logic ec, input string nm);
      rst = 1'b0; a = ai; b = bi; c = ci;
      push_exp(es, ec, nm);
      step();
   endtask

   // Reference: signed integer difference; borrow iff negative, result is the value mod 16.
   task automatic modelled(input logic [3:0] ai, input logic [3:0] bi, input logic ci,
                           input string nm);
      int diff;
      rst = 1'b0; a = ai; b = bi; c = ci;
      diff = int'(ai) - int'(bi) - int'(ci);
      push_exp(4'((diff + 32) % 16), diff < 0, nm);
      step();
   endtask

   task automatic reset_cycle(input string nm);
      rst = 1'b1;
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      c = 1'($urandom_range(0, 1));
      push_exp(4'b0000, 1'b0, nm);
      step();
   endtask

   initial begin
      reset_cycle("reset");
      reset_cycle("reset_hold");
      directed(4'b0001, 4'b0011, 1'b0, 4'b1110, 1'b1, "post_reset_borrow");
      directed(4'b1101, 4'b0011, 1'b0, 4'b1010, 1'b0, "no_borrow_a");
      directed(4'b1111, 4'b1101, 1'b0, 4'b0010, 1'b0, "no_borrow_b");
      directed(4'b0101, 4'b1011, 1'b0, 4'b1010, 1'b1, "borrow");
      directed(4'b0011, 4'b0011, 1'b0, 4'b0000, 1'b0, "equal_c0");
      directed(4'b0110, 4'b0110, 1'b1, 4'b1111, 1'b1, "equal_c1");
      directed(4'b1001, 4'b0011, 1'b1, 4'b0101, 1'b0, "borrow_in_a");
      directed(4'b0001, 4'b1001, 1'b1, 4'b0111, 1'b1, "borrow_in_b");
      directed(4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1, "full_ripple");
      reset_cycle("reset_mid_stream");
      directed(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, "first_after_reset");
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 49) == 0)
            reset_cycle("random_reset");
         else
            modelled(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)), "random");
      end
      for (int i = 0; i < 10 && sb.size() > 0; i++) step();
      if (sb.size() > 0) begin
         errors++;
         checks++;
         $display("FAIL drain: %0d results never checked, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
